// File: rtl/data_mem_responder_if.sv
// rtl/data_mem_responder_if.sv - load/store request and response bundle between the MEM stage and the data memory
interface data_mem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_ready;
  logic        mem_stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, mem_stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, mem_stall
  );
endinterface

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency data memory responder for the core's load/store port
// Byte/halfword accesses exist only with DMEM_SUBWORD_EN defined; otherwise every access is a full word.
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input logic                 clk,
  input logic                 rst,
  data_mem_responder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [2:0]  f3_q, f3_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [31:0] rdata_q, rdata_d;

  logic [31:0] mem [DEPTH];

  logic          c_we;
  logic [AW+1:0] c_addr;
  logic [31:0]   c_wdata;
  logic [2:0]    c_f3;
  logic [AW-1:0] c_idx;
  logic [31:0]   c_word;
  logic [31:0]   c_load;
  logic [31:0]   c_wlane;
  logic [3:0]    c_be;
  logic          enter_resp;

  // With LATENCY=1 the commit happens on the accept edge, so the live request is used instead of the capture.
  always_comb begin
    if (state_q == IDLE) begin
      c_we    = bus.req_we;
      c_addr  = bus.req_addr[AW+1:0];
      c_wdata = bus.req_wdata;
      c_f3    = bus.req_funct3;
    end else begin
      c_we    = we_q;
      c_addr  = addr_q;
      c_wdata = wdata_q;
      c_f3    = f3_q;
    end
    c_idx  = c_addr[AW+1:2];
    c_word = mem[c_idx];
    enter_resp = ((state_q == IDLE) && bus.req_valid && (LATENCY == 1)) ||
                 ((state_q == WAIT) && (cnt_q == 4'd0));
  end

`ifdef DMEM_SUBWORD_EN
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  always_comb begin
    c_be    = 4'b1111;
    c_wlane = c_wdata;
    case (c_f3[1:0])
      2'b00: begin
        c_be    = 4'b0001 << c_addr[1:0];
        c_wlane = {4{c_wdata[7:0]}};
      end
      2'b01: begin
        c_be    = c_addr[1] ? 4'b1100 : 4'b0011;
        c_wlane = {2{c_wdata[15:0]}};
      end
      default: ;
    endcase

    sel_byte = c_word[{c_addr[1:0], 3'b000} +: 8];
    sel_half = c_addr[1] ? c_word[31:16] : c_word[15:0];
    case (c_f3)
      3'b000:  c_load = {{24{sel_byte[7]}}, sel_byte};
      3'b001:  c_load = {{16{sel_half[15]}}, sel_half};
      3'b100:  c_load = {24'h0, sel_byte};
      3'b101:  c_load = {16'h0, sel_half};
      default: c_load = c_word;
    endcase
  end
`else
  logic unused_sub;
  assign unused_sub = ^{c_f3, c_addr[1:0]};

  always_comb begin
    c_be    = 4'b1111;
    c_wlane = c_wdata;
    c_load  = c_word;
  end
`endif

  logic unused_hi;
  assign unused_hi = ^bus.req_addr[31:AW+2];

  always_ff @(posedge clk) begin
    if (enter_resp && c_we) begin
      for (int b = 0; b < 4; b++) begin
        if (c_be[b]) mem[c_idx][8*b +: 8] <= c_wlane[8*b +: 8];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    f3_d        = f3_q;
    rsp_valid_d = rsp_valid_q;
    rdata_d     = rdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          we_d    = bus.req_we;
          addr_d  = bus.req_addr[AW+1:0];
          wdata_d = bus.req_wdata;
          f3_d    = bus.req_funct3;
          if (LATENCY > 1) begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end else begin
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 4'd1;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      rsp_valid_d = 1'b1;
      rdata_d     = c_we ? 32'h0 : c_load;
    end
    req_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'h0;
      f3_q        <= 3'b000;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'h0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      f3_q        <= f3_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign bus.req_ready = req_ready_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rdata_q;
  assign bus.mem_stall = ((state_q == IDLE) && bus.req_valid) || (state_q == WAIT) ||
                         ((state_q == RESP) && !bus.rsp_ready);
endmodule
